uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: detects the falling edge of rx_int, queues rx_data,
// and presents the oldest byte first-word-fall-through with a sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_int,
    output logic [7:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            r0;
    logic            r1;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_nxt;
    logic [CW-1:0]   count_nxt;
    logic [7:0]      dout_nxt;
    logic [7:0]      mem [DEPTH];

    logic            push_c;
    logic            pop_c;
    logic            wr_en_c;
    logic            drop_c;

    // Strobes: a push at full is only accepted when a pop frees the head entry in the same cycle
    always_comb begin
        push_c  = r1 & ~r0;
        pop_c   = dout_ready & (state != S_EMPTY);
        wr_en_c = push_c & ((state != S_FULL) | pop_c);
        drop_c  = push_c & (state == S_FULL) & ~pop_c;
    end

    // Next occupancy, read pointer and control state
    always_comb begin
        count_nxt  = count;
        rd_ptr_nxt = rd_ptr;
        state_nxt  = state;

        case ({wr_en_c, pop_c})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        if (pop_c) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end

        case (state)
            S_EMPTY: begin
                if (wr_en_c) begin
                    state_nxt = S_PARTIAL;
                end
            end
            S_PARTIAL: begin
                if (pop_c && !wr_en_c && count == CNT_ONE) begin
                    state_nxt = S_EMPTY;
                end else if (wr_en_c && !pop_c && count == CNT_LAST) begin
                    state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (pop_c && !wr_en_c) begin
                    state_nxt = S_PARTIAL;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Head byte after this edge; a lone entry being written this edge is not in mem yet
    always_comb begin
        dout_nxt = 8'h00;
        if (state_nxt != S_EMPTY) begin
            if (wr_en_c && count_nxt == CNT_ONE) begin
                dout_nxt = rx_data;
            end else begin
                dout_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Storage array carries no reset; contents are unobservable while empty
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0         <= 1'b0;
            r1         <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= S_EMPTY;
            empty      <= 1'b1;
            full       <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            r0         <= rx_int;
            r1         <= r0;
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            state      <= state_nxt;
            empty      <= (state_nxt == S_EMPTY);
            full       <= (state_nxt == S_FULL);
            dout_valid <= (state_nxt != S_EMPTY);
            dout       <= dout_nxt;
            // A drop on the same edge as a clear leaves the flag set
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
